// File: rtl/mod_arbiter_if.sv
// rtl/mod_arbiter_if.sv - client-side request/response bundle for the shared mod unit arbiter
interface mod_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_A;
  logic [NREQ*W-1:0] req_B;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_result;
  logic              resp_err;

  modport slave (
    input  req_valid, req_A, req_B, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_err
  );

  modport master (
    output req_valid, req_A, req_B, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_err
  );
endinterface

// File: rtl/mod_arbiter.sv
// rtl/mod_arbiter.sv - round-robin sequencer sharing one mod unit among NREQ requesters
module mod_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
) (
  input  logic         clk,
  input  logic         reset,
  mod_arbiter_if.slave cl,
  output logic         busy,
  output logic         mod_start,
  output logic [W-1:0] mod_A,
  output logic [W-1:0] mod_B,
  input  logic [W-1:0] mod_result,
  input  logic         mod_done
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic           err_q, err_d;
  logic           first_q, first_d;
  logic           start_q, start_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;

  logic           found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   cand;
  logic [NREQ-1:0] req_ready;
  logic [W-1:0]   a_arr [NREQ];
  logic [W-1:0]   b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = cl.req_A[i*W +: W];
    assign b_arr[i] = cl.req_B[i*W +: W];
  end

  // First valid requester scanning upward from ptr, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && cl.req_valid[cand[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    err_d     = err_q;
    first_d   = first_q;
    req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (found && !reset) begin
          req_ready[gnt_idx] = 1'b1;
          a_d   = a_arr[gnt_idx];
          b_d   = b_arr[gnt_idx];
          id_d  = gnt_idx;
          ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
          if (b_arr[gnt_idx] == '0) begin
            // B=0 would never terminate in the unit, so answer locally.
            err_d   = 1'b1;
            res_d   = '0;
            state_d = RESP;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        first_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // First WAIT cycle may still show done from the previous op.
        first_d = 1'b0;
        if (!first_q && mod_done) begin
          res_d   = mod_result;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (cl.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    start_d = (state_d == START);
    valid_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      first_q <= first_d;
      start_q <= start_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy           = busy_q;
  assign mod_start      = start_q;
  assign mod_A          = a_q;
  assign mod_B          = b_q;
  assign cl.req_ready   = req_ready;
  assign cl.resp_valid  = valid_q;
  assign cl.resp_id     = id_q;
  assign cl.resp_result = res_q;
  assign cl.resp_err    = err_q;

endmodule
